sys_description_reader: RTL and testbench

- Avalon-MM read master that walks the 64-bit kernel-interface system-description ROM and streams its contents to a downstream consumer (host-interface CSR bridge or parser).
- Word 0 of the ROM is a header whose bits [15:0] give the payload length N in words.
- Payload words 1..N are fetched with pipelined reads, buffered in a small FIFO, and emitted on a valid/ready stream with a last flag.
- Sits between the kernel-interface control logic and the description ROM slave port.

---
 rtl/sys_description_reader.sv | 169 ++++++++++++++++
 tb/tb_sys_description_reader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_description_reader.sv
// ---------------------------------------------------------------------------
// sys_description_reader
//   Avalon-MM read master that walks the system-description ROM. Word 0 is a
//   header whose bits [15:0] give the payload length N; words 1..N are read
//   with pipelined requests, buffered in a small FIFO and streamed out with
//   a last flag on word N.
//
// Ports
//   clk, reset         clock, asynchronous active-high reset
//   start              begin a walk (ignored unless idle)
//   busy               high from accepted start until the done pulse
//   done               one-cycle pulse at the end of a walk
//   len_err            sticky: header length exceeded the ROM; cleared on start
//   m_address/m_read   read request (held stable while m_waitrequest=1)
//   m_waitrequest      slave stall
//   m_readdata/_valid  in-order read responses
//   out_valid/ready    payload stream handshake
//   out_data/out_last  payload word / marks word N
// ---------------------------------------------------------------------------
module sys_description_reader #(
    parameter int ADDR_W          = 9,
    parameter int DATA_W          = 64,
    parameter int FIFO_DEPTH      = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              len_err,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    input  logic              m_waitrequest,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_readdatavalid,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int OST_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam int MAX_LEN_I = (1 << ADDR_W) - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_HWAIT,
        S_STREAM,
        S_FIN
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] rem_issue;
    logic [ADDR_W-1:0] rem_out;
    logic [OST_W-1:0]  outstanding;
    logic [CNT_W-1:0]  fifo_count;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    logic              credit;
    logic              issue_req;
    logic              accept;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              hdr_take;
    logic              hdr_over;
    logic [ADDR_W-1:0] hdr_len;
    logic              fin_ok;

    // Reads in flight plus words already buffered never exceed the FIFO depth,
    // so every response has a slot waiting for it. While a request is stalled
    // this sum can only shrink, which keeps m_read stable through the stall.
    assign credit     = ((int'(outstanding) + int'(fifo_count)) < FIFO_DEPTH) &&
                        (int'(outstanding) < MAX_OUTSTANDING);
    assign issue_req  = (state == S_STREAM) && (rem_issue != '0) && credit;
    assign accept     = issue_req && !m_waitrequest;
    assign push       = (state == S_STREAM) && m_readdatavalid;
    assign fifo_empty = (fifo_count == '0);
    assign pop        = !fifo_empty && out_ready;
    assign fin_ok     = fifo_empty && (outstanding == '0);

    assign hdr_take   = (state == S_HWAIT) && m_readdatavalid;
    assign hdr_over   = int'(m_readdata[15:0]) > MAX_LEN_I;
    assign hdr_len    = hdr_over ? ADDR_W'(MAX_LEN_I) : m_readdata[ADDR_W-1:0];

    assign busy       = (state != S_IDLE);
    assign m_read     = (state == S_HDR) || issue_req;
    assign m_address  = issue_req ? next_addr : '0;
    assign out_valid  = !fifo_empty;
    assign out_data   = fifo_empty ? '0 : mem[rd_ptr];
    assign out_last   = !fifo_empty && (rem_out == ADDR_W'(1));

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (start) state_nx = S_HDR;
            S_HDR:    if (!m_waitrequest) state_nx = S_HWAIT;
            S_HWAIT:  if (m_readdatavalid) state_nx = (hdr_len == '0) ? S_FIN : S_STREAM;
            S_STREAM: if (pop && (rem_out == ADDR_W'(1))) state_nx = S_FIN;
            S_FIN:    if (fin_ok) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            done        <= 1'b0;
            len_err     <= 1'b0;
            next_addr   <= '0;
            rem_issue   <= '0;
            rem_out     <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            state <= state_nx;
            done  <= (state == S_FIN) && fin_ok;

            if ((state == S_IDLE) && start)
                len_err <= 1'b0;
            else if (hdr_take && hdr_over)
                len_err <= 1'b1;

            if (hdr_take) begin
                next_addr <= ADDR_W'(1);
                rem_issue <= hdr_len;
                rem_out   <= hdr_len;
            end else if (accept) begin
                next_addr <= next_addr + ADDR_W'(1);
                rem_issue <= rem_issue - ADDR_W'(1);
            end

            if (pop)
                rem_out <= rem_out - ADDR_W'(1);

            if (accept && !push)
                outstanding <= outstanding + OST_W'(1);
            else if (!accept && push)
                outstanding <= outstanding - OST_W'(1);

            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);

            if (push && !pop)
                fifo_count <= fifo_count + CNT_W'(1);
            else if (!push && pop)
                fifo_count <= fifo_count - CNT_W'(1);
        end
    end

    // Storage needs no reset: fifo_count gates everything read from it.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= m_readdata;
    end

endmodule

// File: tb/tb_sys_description_reader.sv
// ---------------------------------------------------------------------------
// tb_sys_description_reader
//   Table of walks against a ROM/slave model with configurable latency and
//   random stalls; expected stream and address sequence come from the header
//   rules (length clamp, words 1..N in order, last on word N).
// ---------------------------------------------------------------------------
module tb_sys_description_reader;

    localparam int ADDR_W     = 9;
    localparam int DATA_W     = 64;
    localparam int FIFO_DEPTH = 8;
    localparam int MAX_OUT    = 4;
    localparam int ROM_MAX    = (1 << ADDR_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              busy, done, len_err;
    logic [ADDR_W-1:0] m_address;
    logic              m_read;
    logic              m_waitrequest = 1'b0;
    logic [DATA_W-1:0] m_readdata = '0;
    logic              m_readdatavalid = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    sys_description_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .len_err(len_err), .m_address(m_address), .m_read(m_read),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
        .m_readdatavalid(m_readdatavalid), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_le(input string name, input longint got, input longint lim);
        checks++;
        if (got > lim) begin
            errors++;
            $display("FAIL %s: got %0d expected at most %0d", name, got, lim);
        end
    endtask

    // ROM and slave model
    logic [DATA_W-1:0] rom [0:ROM_MAX];
    typedef struct { int addr; int due; } pend_t;
    pend_t pend[$];

    int lat = 2, stall_pct = 0, ready_mode = 0, ready_hold = 0;

    // Observation logs
    int          cyc = 0;
    int          issued[$];
    logic [63:0] got_data[$];
    bit          got_last[$];
    int done_cnt, done_cyc, hdr_rsp_cyc, first_prsp_cyc, first_val_cyc;
    int stab_err, busy_err, valid_seen, max_ost, max_cred;
    int acc_payload, pop_cnt, rsp_cnt;
    bit prev_stall, prev_hold, prev_last;
    logic [ADDR_W-1:0] prev_addr;
    logic [63:0]       prev_data;

    task automatic clear_logs();
        issued.delete(); got_data.delete(); got_last.delete();
        done_cnt = 0; done_cyc = -1; hdr_rsp_cyc = -1;
        first_prsp_cyc = -1; first_val_cyc = -1;
        stab_err = 0; busy_err = 0; valid_seen = 0; max_ost = 0; max_cred = 0;
        acc_payload = 0; pop_cnt = 0; rsp_cnt = 0;
    endtask

    // All DUT outputs are functions of registered state only, so they are
    // settled at the falling edge; inputs for the next rising edge are chosen here.
    always @(negedge clk) begin
        pend_t p;
        cyc++;
        m_readdatavalid = 1'b0;
        m_readdata      = {$urandom, $urandom};
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            p = pend.pop_front();
            m_readdatavalid = 1'b1;
            m_readdata      = rom[p.addr];
            rsp_cnt++;
            if (p.addr == 0) hdr_rsp_cyc = cyc;
            else if (first_prsp_cyc < 0) first_prsp_cyc = cyc;
        end
        if (reset) begin
            m_waitrequest = 1'b0;
            out_ready     = 1'b0;
            prev_stall    = 1'b0;
            prev_hold     = 1'b0;
        end else begin
            if (prev_stall && (!m_read || m_address != prev_addr)) stab_err++;
            if (prev_hold && (!out_valid || out_data != prev_data || out_last != prev_last)) stab_err++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (busy) busy_err++;
            end
            if (out_valid) begin
                valid_seen++;
                if (first_val_cyc < 0) first_val_cyc = cyc;
            end
            m_waitrequest = (stall_pct > 0) && ($urandom_range(99) < stall_pct);
            if (ready_hold > 0) begin
                out_ready = 1'b0;
                ready_hold--;
            end else if (ready_mode == 1) begin
                out_ready = 1'($urandom_range(1));
            end else begin
                out_ready = 1'b1;
            end
            if (m_read && !m_waitrequest) begin
                issued.push_back(int'(m_address));
                pend.push_back('{int'(m_address), cyc + lat});
                if (m_address != 0) acc_payload++;
            end
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                pop_cnt++;
            end
            if (issued.size() - rsp_cnt > max_ost) max_ost = issued.size() - rsp_cnt;
            if (acc_payload - pop_cnt > max_cred) max_cred = acc_payload - pop_cnt;
            prev_stall = m_read && m_waitrequest;
            prev_addr  = m_address;
            prev_hold  = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    typedef struct {
        int hdr; int lat; int stall; int rmode; int hold;
        bit special; bit start_mid; int exp_n; bit exp_err;
    } vec_t;

    task automatic run_walk(input vec_t v);
        int n, bad, k;
        n = v.exp_n;
        rom[0] = {32'($urandom), 16'($urandom), 16'(v.hdr)};
        for (int i = 1; i <= ROM_MAX; i++) rom[i] = {$urandom, $urandom};
        if (v.special) begin
            rom[1] = 64'hA1; rom[2] = 64'hA2; rom[3] = 64'hA3;
        end
        lat = v.lat; stall_pct = v.stall; ready_mode = v.rmode;
        @(negedge clk);
        clear_logs();
        ready_hold = v.hold;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_to_read", {busy, m_read, len_err, 9'(m_address)}, {1'b1, 1'b1, 1'b0, 9'd0});
        if (v.hold > 0) begin
            repeat (v.hold - 3) @(negedge clk);
            chk("reads_during_hold", acc_payload, FIFO_DEPTH);
        end
        if (v.start_mid) begin
            repeat (20) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            chk("start_while_busy", {busy, len_err}, {1'b1, v.exp_err});
        end
        for (k = 0; k < 20000 && done_cnt == 0; k++) @(negedge clk);
        if (done_cnt == 0) $display("FAIL done_timeout: got no done within %0d cycles, expected one", k);
        repeat (5) @(negedge clk);
        chk("done_count", done_cnt, 1);
        chk("busy_at_done", busy_err, 0);
        chk("idle_after", busy, 0);
        chk("len_err", len_err, v.exp_err);
        chk("words_out", got_data.size(), n);
        bad = 0;
        for (int i = 0; i < got_data.size(); i++)
            if (i >= n || got_data[i] != rom[i+1] || got_last[i] != (i == n - 1)) bad++;
        chk("data_last", bad, 0);
        bad = (issued.size() == n + 1) ? 0 : 1;
        for (int i = 0; i < issued.size(); i++) if (issued[i] != i) bad++;
        chk("addresses", bad, 0);
        chk("stability", stab_err, 0);
        chk_le("outstanding", max_ost, MAX_OUT);
        chk_le("fifo_credit", max_cred, FIFO_DEPTH);
        if (n == 0) begin
            chk("len0_valid", valid_seen, 0);
            chk("len0_done_lat", done_cyc - hdr_rsp_cyc, 2);
        end else begin
            chk("rdv_to_valid", first_val_cyc - first_prsp_cyc, 1);
        end
    endtask

    vec_t vecs[$];
    vec_t rv;

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation time limit, expected $finish");
        $fatal(1);
    end

    initial begin
        clear_logs();
        reset = 1'b1;
        start = 1'b0;
        #1;
        chk("reset_outputs", {busy, done, len_err, m_read, out_valid, out_last,
                              9'(m_address), out_data}, '0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        //          hdr  lat stall rmode hold spec mid   n  err
        vecs.push_back('{3,      2,  0, 0,  0, 1, 0,   3, 0});
        vecs.push_back('{0,      2,  0, 0,  0, 0, 0,   0, 0});
        vecs.push_back('{16'h400,2,  0, 0,  0, 0, 1, 511, 1});
        vecs.push_back('{2,      2,  0, 0,  0, 0, 0,   2, 0});
        vecs.push_back('{20,     2,  0, 0, 50, 0, 0,  20, 0});
        vecs.push_back('{10,     2, 50, 0,  0, 0, 0,  10, 0});
        vecs.push_back('{16,     3, 30, 1,  0, 0, 0,  16, 0});
        vecs.push_back('{511,    1,  0, 0,  0, 0, 0, 511, 0});
        vecs.push_back('{512,    4, 20, 1,  0, 0, 0, 511, 1});
        for (int i = 0; i < 4; i++) begin
            rv.hdr   = $urandom_range(40, 1);
            rv.lat   = $urandom_range(4, 1);
            rv.stall = $urandom_range(60);
            rv.rmode = 1; rv.hold = 0; rv.special = 0; rv.start_mid = 0;
            rv.exp_n = (rv.hdr > ROM_MAX) ? ROM_MAX : rv.hdr;
            rv.exp_err = (rv.hdr > ROM_MAX);
            vecs.push_back(rv);
        end
        foreach (vecs[i]) run_walk(vecs[i]);

        // Reset in the middle of a walk, then a clean walk.
        for (int i = 0; i <= ROM_MAX; i++) rom[i] = {$urandom, $urandom};
        rom[0] = 64'd10;
        lat = 2; stall_pct = 0; ready_mode = 0;
        @(negedge clk);
        clear_logs();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 200 && pop_cnt < 4; k++) @(negedge clk);
        chk("pops_before_reset", pop_cnt, 4);
        reset = 1'b1;
        #1;
        chk("midwalk_reset_outputs", {busy, done, len_err, m_read, out_valid, out_last,
                                      9'(m_address), out_data}, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_logs();
        repeat (12) @(negedge clk);
        chk("no_done_after_reset", done_cnt, 0);
        chk("late_rdv_ignored", valid_seen, 0);
        chk("no_reads_after_reset", issued.size(), 0);
        chk("pend_drained", pend.size(), 0);
        rv = '{10, 2, 0, 0, 0, 0, 0, 10, 0};
        run_walk(rv);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
